// File: rtl/qint_vector_pkg.sv
// Shared types and helpers for the QBUS interrupt-vector reply stage.
package qint_vector_pkg;

  typedef enum logic [1:0] {
    QV_IDLE    = 2'd0,
    QV_SETUP   = 2'd1,
    QV_REPLY   = 2'd2,
    QV_RELEASE = 2'd3
  } qv_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/qint_vector_qsync.sv
// Multi-flop single-bit synchroniser for asynchronous bus receivers.
module qsync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/qint_vector.sv
// Drives the interrupt vector onto DAL and handshakes TRPLY against RDIN for one IAK cycle.
module qint_vector
  import qint_vector_pkg::*;
#(
  parameter int DAL_WIDTH      = 22,
  parameter int SYNC_STAGES    = 2,
  parameter int SETUP_CYCLES   = 3,
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 RINIT,
  input  logic                 RDIN,
  input  logic                 assert_vector,
  input  logic [8:0]           vector,
  output logic [DAL_WIDTH-1:0] TDAL,
  output logic                 dal_oe,
  output logic                 TRPLY,
  output logic                 vector_done,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int CNT_W = $clog2(max3(SETUP_CYCLES, HOLD_CYCLES, TIMEOUT_CYCLES) + 1);

  logic av_s, rdin_s, init_s, sync_rdy;

  qsync #(.STAGES(SYNC_STAGES)) u_sync_av   (.clk(clk), .rst_n(reset_n), .d_i(assert_vector), .q_o(av_s));
  qsync #(.STAGES(SYNC_STAGES)) u_sync_rdin (.clk(clk), .rst_n(reset_n), .d_i(RDIN),          .q_o(rdin_s));
  qsync #(.STAGES(SYNC_STAGES)) u_sync_init (.clk(clk), .rst_n(reset_n), .d_i(RINIT),         .q_o(init_s));
  // Goes high once the chains hold post-reset samples, so a held assert_vector cannot fake an edge.
  qsync #(.STAGES(SYNC_STAGES)) u_sync_rdy  (.clk(clk), .rst_n(reset_n), .d_i(1'b1),          .q_o(sync_rdy));

  qv_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DAL_WIDTH-1:0] tdal_q, tdal_d;
  logic                 dal_oe_q, dal_oe_d;
  logic                 trply_q, trply_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 terr_q, terr_d;
  logic                 av_low_q;
  logic                 start, setup_done, reply_to, hold_done;

  assign start      = av_s & av_low_q & ~init_s;
  assign setup_done = (cnt_q == CNT_W'(SETUP_CYCLES - 1));
  assign reply_to   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign hold_done  = (cnt_q == CNT_W'(HOLD_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= QV_IDLE;
      cnt_q    <= '0;
      tdal_q   <= '0;
      dal_oe_q <= 1'b0;
      trply_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
      av_low_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tdal_q   <= tdal_d;
      dal_oe_q <= dal_oe_d;
      trply_q  <= trply_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      terr_q   <= terr_d;
      av_low_q <= sync_rdy & ~av_s;
    end
  end

  always_comb begin
    state_d = state_q;
    if (init_s) begin
      state_d = QV_IDLE;
    end else begin
      case (state_q)
        QV_IDLE:    if (start) state_d = QV_SETUP;
        QV_SETUP: begin
          if (!av_s)           state_d = QV_IDLE;
          else if (setup_done) state_d = QV_REPLY;
        end
        QV_REPLY:   if (!rdin_s || reply_to) state_d = QV_RELEASE;
        QV_RELEASE: if (hold_done) state_d = QV_IDLE;
        default:    state_d = QV_IDLE;
      endcase
    end
  end

  // Registered outputs are derived from the transition about to be taken.
  always_comb begin
    cnt_d    = (state_d != state_q || state_q == QV_IDLE) ? '0 : cnt_q + CNT_W'(1);
    dal_oe_d = (state_d != QV_IDLE);
    busy_d   = (state_d != QV_IDLE);
    trply_d  = (state_d == QV_REPLY);
    tdal_d   = tdal_q;
    terr_d   = terr_q;
    done_d   = 1'b0;
    if (state_q == QV_IDLE && state_d == QV_SETUP) begin
      tdal_d = {{(DAL_WIDTH-9){1'b0}}, vector & 9'h1FC};
      terr_d = 1'b0;
    end else if (state_d == QV_IDLE) begin
      tdal_d = '0;
    end
    if (state_q == QV_REPLY && state_d == QV_RELEASE && rdin_s) terr_d = 1'b1;
    if (state_q == QV_RELEASE && state_d == QV_IDLE && !init_s && !terr_q) done_d = 1'b1;
  end

  assign TDAL        = tdal_q;
  assign dal_oe      = dal_oe_q;
  assign TRPLY       = trply_q;
  assign vector_done = done_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_qint_vector.sv
// Bench for qint_vector: timestamp-based reference model plus directed IAK scenarios.
module tb_qint_vector;

  localparam int DW      = 22;
  localparam int SYNC    = 2;
  localparam int SETUP   = 3;
  localparam int HOLD    = 2;
  localparam int TIMEOUT = 200;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          RINIT, RDIN, assert_vector;
  logic [8:0]    vector;
  logic [DW-1:0] TDAL;
  logic          dal_oe, TRPLY, vector_done, busy, timeout_err;

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;

  qint_vector #(.DAL_WIDTH(DW), .SYNC_STAGES(SYNC), .SETUP_CYCLES(SETUP),
                .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .RINIT(RINIT), .RDIN(RDIN),
    .assert_vector(assert_vector), .vector(vector), .TDAL(TDAL), .dal_oe(dal_oe),
    .TRPLY(TRPLY), .vector_done(vector_done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model: each transfer is described by the edge index at which its
  // phases began; outputs follow from elapsed edge counts.
  logic [SYNC-1:0] h_av, h_rdin, h_init;
  int              m_edges, m_ps, m_ts, m_rs;
  logic            m_act, m_terr, m_done, m_armed;
  logic [DW-1:0]   m_vec;

  always @(posedge clk or negedge reset_n) begin : model
    logic s_av, s_rdin, s_init, valid, act, te, dn;
    int n, ps, ts, rs;
    logic [DW-1:0] v;
    if (!reset_n) begin
      h_av <= '0; h_rdin <= '0; h_init <= '0;
      m_edges <= 0; m_ps <= 0; m_ts <= -1; m_rs <= -1;
      m_act <= 1'b0; m_terr <= 1'b0; m_done <= 1'b0; m_armed <= 1'b0; m_vec <= '0;
    end else begin
      s_av = h_av[SYNC-1]; s_rdin = h_rdin[SYNC-1]; s_init = h_init[SYNC-1];
      valid = (m_edges >= SYNC);
      n = m_edges; act = m_act; ps = m_ps; ts = m_ts; rs = m_rs; te = m_terr; v = m_vec;
      dn = 1'b0;
      if (s_init) begin
        act = 1'b0;
      end else if (!act) begin
        if (s_av && m_armed) begin
          act = 1'b1; ps = n; ts = -1; rs = -1; te = 1'b0;
          v = DW'(vector) / 4 * 4;
        end
      end else if (ts < 0) begin
        if (!s_av) act = 1'b0;
        else if (n - ps == SETUP) ts = n;
      end else if (rs < 0) begin
        if (!s_rdin) rs = n;
        else if (n - ts == TIMEOUT) begin rs = n; te = 1'b1; end
      end else if (n - rs == HOLD) begin
        act = 1'b0; dn = !te;
      end
      m_act <= act; m_ps <= ps; m_ts <= ts; m_rs <= rs; m_terr <= te; m_vec <= v; m_done <= dn;
      m_armed <= valid && !s_av;
      m_edges <= m_edges + 1;
      h_av   <= {h_av[SYNC-2:0], assert_vector};
      h_rdin <= {h_rdin[SYNC-2:0], RDIN};
      h_init <= {h_init[SYNC-2:0], RINIT};
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_dal_oe", 32'(dal_oe), 32'(m_act));
    chk("cyc_TRPLY", 32'(TRPLY), 32'(m_act && m_ts >= 0 && m_rs < 0));
    chk("cyc_TDAL", 32'(TDAL), m_act ? 32'(m_vec) : 32'd0);
    chk("cyc_busy", 32'(busy), 32'(m_act));
    chk("cyc_vector_done", 32'(vector_done), 32'(m_done));
    chk("cyc_timeout_err", 32'(timeout_err), 32'(m_terr));
  end

  always @(negedge clk) if (vector_done === 1'b1) n_done <= n_done + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // which: 0 = dal_oe, 1 = TRPLY
  task automatic wait_sig(input string nm, input int which, input logic val, output int cyc);
    logic cur;
    cyc = 0;
    for (int i = 0; i < 500; i++) begin
      cur = (which == 0) ? dal_oe : TRPLY;
      if (cur === val) return;
      tick(1);
      cyc++;
    end
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait expired, got %0b, expected %0b", nm, cur, val);
  endtask

  task automatic finish_xfer(input string nm);
    int c;
    RDIN = 1'b0;
    wait_sig({nm, "_trply_low"}, 1, 1'b0, c);
    wait_sig({nm, "_oe_low"}, 0, 1'b0, c);
    assert_vector = 1'b0;
    tick(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, d0;
    logic seen;
    reset_n = 1'b0; RINIT = 1'b0; RDIN = 1'b0; assert_vector = 1'b0; vector = '0;
    tick(2);
    chk("reset_dal_oe", 32'(dal_oe), 32'd0);
    chk("reset_TRPLY", 32'(TRPLY), 32'd0);
    chk("reset_TDAL", 32'(TDAL), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_terr", 32'(timeout_err), 32'd0);
    reset_n = 1'b1;
    tick(4);

    // 1: normal IAK with vector 0234 octal
    vector = 9'o234; RDIN = 1'b1; assert_vector = 1'b1;
    wait_sig("t1_oe_high", 0, 1'b1, c);
    chk("t1_TDAL", 32'(TDAL), 32'h09C);
    wait_sig("t1_trply_high", 1, 1'b1, c);
    chk("t1_setup_clks", 32'(c), 32'd3);
    tick(3);
    RDIN = 1'b0;
    d0 = n_done;
    wait_sig("t1_trply_low", 1, 1'b0, c);
    chk("t1_oe_still_high", 32'(dal_oe), 32'd1);
    wait_sig("t1_oe_low", 0, 1'b0, c);
    chk("t1_hold_clks", 32'(c), 32'd2);
    chk("t1_done_pulse", 32'(vector_done), 32'd1);
    tick(1);
    chk("t1_done_cleared", 32'(vector_done), 32'd0);
    chk("t1_done_count", 32'(n_done - d0), 32'd1);
    tick(4);
    chk("t1_no_retrigger", 32'(busy), 32'd0);
    assert_vector = 1'b0;
    tick(3);

    // 2: low vector bits forced to zero, later vector changes ignored
    vector = 9'h1FF; RDIN = 1'b1; assert_vector = 1'b1;
    wait_sig("t2_oe_high", 0, 1'b1, c);
    chk("t2_TDAL_setup", 32'(TDAL), 32'h1FC);
    vector = 9'h000;
    wait_sig("t2_trply_high", 1, 1'b1, c);
    chk("t2_TDAL_reply", 32'(TDAL), 32'h1FC);
    finish_xfer("t2");

    // 3: RDIN never negates
    vector = 9'o100; RDIN = 1'b1; assert_vector = 1'b1;
    wait_sig("t3_trply_high", 1, 1'b1, c);
    d0 = n_done;
    wait_sig("t3_trply_low", 1, 1'b0, c);
    chk("t3_reply_clks", 32'(c), 32'd200);
    chk("t3_terr", 32'(timeout_err), 32'd1);
    tick(4);
    chk("t3_idle", 32'(busy), 32'd0);
    chk("t3_no_done", 32'(n_done - d0), 32'd0);
    assert_vector = 1'b0; RDIN = 1'b0;
    tick(3);
    RDIN = 1'b1; assert_vector = 1'b1;
    wait_sig("t3b_oe_high", 0, 1'b1, c);
    chk("t3_terr_cleared", 32'(timeout_err), 32'd0);
    wait_sig("t3b_trply_high", 1, 1'b1, c);
    finish_xfer("t3b");

    // 4: IAK aborted during setup
    vector = 9'o070; RDIN = 1'b1; assert_vector = 1'b1;
    d0 = n_done;
    wait_sig("t4_oe_high", 0, 1'b1, c);
    assert_vector = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (TRPLY === 1'b1) seen = 1'b1;
    end
    chk("t4_trply_never", 32'(seen), 32'd0);
    chk("t4_oe_low", 32'(dal_oe), 32'd0);
    chk("t4_busy_low", 32'(busy), 32'd0);
    chk("t4_no_done", 32'(n_done - d0), 32'd0);

    // 5: RINIT during REPLY
    vector = 9'o314; RDIN = 1'b1; assert_vector = 1'b1;
    wait_sig("t5_trply_high", 1, 1'b1, c);
    tick(2);
    d0 = n_done;
    RINIT = 1'b1;
    wait_sig("t5_trply_low", 1, 1'b0, c);
    chk("t5_init_clks", 32'(c), 32'(SYNC + 1));
    chk("t5_oe_low", 32'(dal_oe), 32'd0);
    chk("t5_busy_low", 32'(busy), 32'd0);
    RINIT = 1'b0; assert_vector = 1'b0;
    tick(4);
    chk("t5_no_done", 32'(n_done - d0), 32'd0);

    // 6: async reset mid-REPLY, assert_vector held across reset release
    vector = 9'o004; RDIN = 1'b1; assert_vector = 1'b1;
    wait_sig("t6_trply_high", 1, 1'b1, c);
    tick(2);
    reset_n = 1'b0;
    #1;
    chk("t6_async_oe", 32'(dal_oe), 32'd0);
    chk("t6_async_TRPLY", 32'(TRPLY), 32'd0);
    chk("t6_async_TDAL", 32'(TDAL), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(10);
    chk("t6_held_no_start", 32'(busy), 32'd0);
    chk("t6_held_no_oe", 32'(dal_oe), 32'd0);
    assert_vector = 1'b0;
    tick(3);
    assert_vector = 1'b1;
    wait_sig("t6_rearm_oe", 0, 1'b1, c);
    chk("t6_rearm_busy", 32'(busy), 32'd1);
    chk("t6_rearm_TDAL", 32'(TDAL), 32'h004);
    wait_sig("t6_trply_high2", 1, 1'b1, c);
    finish_xfer("t6");

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
